// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and a shift-add multiplier.
// Optional zero/overflow flag outputs are built only when ALU_FLAGS_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t           state;
  state_t           state_n;
  logic             accept;
  logic             is_mul;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [SHW:0]     cnt;
  logic             last_step;

  assign shamt     = B[SHW-1:0];
  assign is_mul    = (ALUOp == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign acc_step  = mplier[0] ? (acc + mcand) : acc;
  assign last_step = (cnt == CNT_ONE);

  // Single-cycle datapath; MUL is resolved by the iterative unit below.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        alu_res = A + B;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = A - B;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // in_ready in DONE follows out_ready combinationally so a retiring result
  // and a new issue can share a cycle.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_step) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_n = is_mul ? S_MUL : S_DONE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef ALU_FLAGS_EN
      zero     <= 1'b0;
      overflow <= 1'b0;
`endif
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= CNT_INIT;
      end else begin
        C <= alu_res;
`ifdef ALU_FLAGS_EN
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
`endif
      end
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_ONE;
      if (last_step) begin
        C <= acc_step;
`ifdef ALU_FLAGS_EN
        zero     <= (acc_step == '0);
        overflow <= 1'b0;
`endif
      end
    end
  end

`ifndef ALU_FLAGS_EN
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  aluop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] C;
  logic        busy;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_i),
    .B         (b_i),
    .ALUOp     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .busy      (busy)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'(longint'($signed(a)) >>> sh);
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (op == 4'd0)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd1) r = longint'($signed(a)) - longint'($signed(b));
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Issues one op from idle with out_ready high and returns the result and
  // the number of cycles until out_valid (-1 if it never came).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; aluop = op; a_i = a; b_i = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 100; i++) begin
      if (out_valid) begin
        lat = i;
        res = C;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (C !== 32'd0) begin bad++; $display("FAIL reset_c got=%h want=0", C); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd0; a_i = 32'd9; b_i = 32'd9; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (C !== 32'd18) begin bad++; $display("FAIL held_add got=%h want=%h", C, 32'd18); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid got=%b want=0", out_valid); end
    total++; if (C !== 32'd0) begin bad++; $display("FAIL async_reset_c got=%h want=0", C); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    begin
      logic [31:0] r;
      int          lat;
      run_op(4'd0, 32'd5, 32'd7, r, lat);
      total++; if (r !== 32'd12) begin bad++; $display("FAIL add_5_7 got=%h want=%h", r, 32'd12); end
      total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    end
  endtask

  task automatic test_ops();
    logic [3:0]  ops [6]  = '{4'd1, 4'd5, 4'd6, 4'd9, 4'd7, 4'd13};
    logic [31:0] as  [6]  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h1234};
    logic [31:0] bs  [6]  = '{32'd5, 32'd1, 32'd1, 32'd4, 32'd35, 32'h5678};
    logic [31:0] exp_d[6] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'd8, 32'd0};
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat);
      total++; if (r !== exp_d[i]) begin bad++; $display("FAIL op_sweep[%0d] op=%0d got=%h want=%h", i, ops[i], r, exp_d[i]); end
    end
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      run_op(op, a, b, r, lat);
      total++; if (r !== model(op, a, b)) begin bad++; $display("FAIL rand_op op=%0d a=%h b=%h got=%h want=%h", op, a, b, r, model(op, a, b)); end
      total++; if (lat !== ((op == 4'd10) ? 33 : 1)) begin bad++; $display("FAIL rand_latency op=%0d got=%0d want=%0d", op, lat, (op == 4'd10) ? 33 : 1); end
    end
  endtask

  task automatic test_mul();
    int          busy_bad = 0;
    logic [31:0] r;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd10; a_i = 32'h12345; b_i = 32'h100; out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      // Garbage offered during the multiply must be ignored.
      aluop = 4'd0; a_i = $urandom(); b_i = $urandom();
      if (i == 32) in_valid = 1'b0;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
    end
    total++; if (busy_bad !== 0) begin bad++; $display("FAIL mul_busy_window got=%0d bad cycles want=0", busy_bad); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_out_valid_33 got=%b want=1", out_valid); end
    total++; if (C !== 32'h01234500) begin bad++; $display("FAIL mul_result got=%h want=%h", C, 32'h01234500); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_done got=%b want=0", busy); end
    run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL mul_all_ones got=%h want=1", r); end
  endtask

  task automatic test_backpressure();
    int hold_bad = 0;
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd0; a_i = 32'd10; b_i = 32'd20; out_ready = 1'b0;
    @(negedge clk);
    a_i = 32'd1; b_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || C !== 32'd30 || in_ready !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL backpressure_hold got=%0d bad cycles want=0", hold_bad); end
    total++; if (C !== 32'd30) begin bad++; $display("FAIL backpressure_c got=%h want=%h", C, 32'd30); end
    out_ready = 1'b1; a_i = 32'd100; b_i = 32'd200;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (C !== 32'd300 || out_valid !== 1'b1) begin bad++; $display("FAIL release_new_result got=%h/%b want=%h/1", C, out_valid, 32'd300); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] want;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        want = q.pop_front();
        total++; if (out_valid !== 1'b1 || C !== want) begin bad++; $display("FAIL stream[%0d] got=%h/%b want=%h/1", i - 1, C, out_valid, want); end
      end
      if (i < 4) begin
        in_valid = 1'b1; aluop = 4'd0; a_i = $urandom(); b_i = $urandom();
        q.push_back(model(4'd0, a_i, b_i));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    int          seen = 0;
    logic [31:0] r, a, b;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd10; a_i = 32'd7; b_i = 32'd9; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy got=%b want=1", busy); end
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_mul_reset got=busy%b/ov%b/ir%b want=0/0/1", busy, out_valid, in_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL aborted_mul_result got=%0d valid cycles want=0", seen); end
    a = $urandom(); b = $urandom();
    run_op(4'd4, a, b, r, lat);
    total++; if (r !== (a ^ b)) begin bad++; $display("FAIL after_abort got=%h want=%h", r, a ^ b); end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 20; i++) begin
      case (i)
        0: begin op = 4'd0; a = 32'h7FFFFFFF; b = 32'd1; end
        1: begin op = 4'd1; a = 32'd9; b = 32'd9; end
        2: begin op = 4'd1; a = 32'h80000000; b = 32'd1; end
        3: begin op = 4'd10; a = 32'h10000; b = 32'h10000; end
        default: begin op = 4'($urandom_range(0, 2)); a = $urandom(); b = $urandom(); end
      endcase
      run_op(op, a, b, r, lat);
      total++; if (zero !== (model(op, a, b) == 32'd0)) begin bad++; $display("FAIL flag_zero[%0d] got=%b want=%b", i, zero, model(op, a, b) == 32'd0); end
      total++; if (overflow !== ovf_model(op, a, b)) begin bad++; $display("FAIL flag_ovf[%0d] got=%b want=%b", i, overflow, ovf_model(op, a, b)); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; aluop = '0;
    test_reset();
    test_ops();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
